// File: rtl/fan_duty_ramp_if.sv
// Signal bundle between the fan level source and the duty ramp stage.
// Every signal is qualified by clk_en_i. There is no valid/ready pair:
// level_i, step_i and kickValue_i are sampled on each enabled clock edge.
// counterValue_o, fanOn_o and state_o are registered and change only on
// enabled edges, or on reset.
interface fan_duty_ramp_if #(
  parameter int COUNTER_BITWIDTH = 8,
  parameter int LEVEL_BITWIDTH   = 4
);
  logic                        clk_en_i;
  logic [LEVEL_BITWIDTH-1:0]   level_i;
  logic [COUNTER_BITWIDTH-1:0] step_i;
  logic [COUNTER_BITWIDTH-1:0] kickValue_i;
  logic [COUNTER_BITWIDTH-1:0] counterValue_o;
  logic                        fanOn_o;
  logic [1:0]                  state_o;

  modport master (
    output clk_en_i, level_i, step_i, kickValue_i,
    input  counterValue_o, fanOn_o, state_o
  );

  modport slave (
    input  clk_en_i, level_i, step_i, kickValue_i,
    output counterValue_o, fanOn_o, state_o
  );
endinterface

// File: rtl/fan_duty_ramp.sv
// Fan duty ramp. Maps a level request to a PWM compare value.
// When the fan starts from stopped, a kick-start value is held first.
// After that, the duty slews toward the target in bounded steps.
module fan_duty_ramp #(
  parameter int COUNTER_BITWIDTH = 8,
  parameter int LEVEL_BITWIDTH   = 4,
  parameter int STEP_PRESCALE    = 16,
  parameter int KICK_TICKS       = 64
) (
  input logic           clk_i,
  input logic           rst_i,
  fan_duty_ramp_if.slave bus
);
  localparam int CW    = COUNTER_BITWIDTH;
  localparam int LW    = LEVEL_BITWIDTH;
  localparam int PW    = (STEP_PRESCALE > 1) ? $clog2(STEP_PRESCALE) : 1;
  localparam int KW    = (KICK_TICKS > 1) ? $clog2(KICK_TICKS) : 1;
  localparam int SCALE = ((2 ** CW) - 1) / ((2 ** LW) - 1);

  localparam logic [CW+LW-1:0] SCALE_W   = (CW+LW)'(SCALE);
  localparam logic [PW-1:0]    PRE_LAST  = PW'(STEP_PRESCALE - 1);
  localparam logic [KW-1:0]    KICK_LOAD = (KICK_TICKS > 0) ? KW'(KICK_TICKS - 1) : '0;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_KICK = 2'd1,
    S_RAMP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_pre;
  logic [KW-1:0] r_kick;
  logic          r_fan_on;

  state_t        w_state_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [PW-1:0] w_pre_nxt;
  logic [KW-1:0] w_kick_nxt;

  logic [CW+LW-1:0] w_product;
  logic [CW-1:0]    w_target;
  logic [CW-1:0]    w_step;
  logic [CW:0]      w_up_sum;
  logic [CW:0]      w_down_floor;
  logic [CW-1:0]    w_up_val;
  logic [CW-1:0]    w_down_val;
  logic [CW-1:0]    w_stepped;

  // Target duty. The product is formed at full width. It never exceeds
  // the counter range by construction of SCALE.
  assign w_product = (CW+LW)'(bus.level_i) * SCALE_W;
  assign w_target  = CW'(w_product);

  // A zero step would stall the ramp forever, so it is promoted to 1.
  assign w_step = (bus.step_i == '0) ? CW'(1) : bus.step_i;

  // The candidate values are computed one bit wider than the counter.
  // Up-ramps therefore clamp at the target, and down-ramps do not underflow.
  assign w_up_sum     = {1'b0, r_count} + {1'b0, w_step};
  assign w_down_floor = {1'b0, w_target} + {1'b0, w_step};
  assign w_up_val     = (w_up_sum >= {1'b0, w_target}) ? w_target : w_up_sum[CW-1:0];
  assign w_down_val   = ({1'b0, r_count} <= w_down_floor) ? w_target : (r_count - w_step);
  assign w_stepped    = (r_count < w_target) ? w_up_val : w_down_val;

  // Next-state and next-register logic. Everything defaults to hold.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_pre_nxt   = r_pre;
    w_kick_nxt  = r_kick;
    case (r_state)
      S_OFF: begin
        if (w_target != '0) begin
          if (KICK_TICKS > 0) begin
            w_state_nxt = S_KICK;
            w_count_nxt = bus.kickValue_i;
            w_kick_nxt  = KICK_LOAD;
          end else begin
            w_state_nxt = S_RAMP;
            w_count_nxt = '0;
            w_pre_nxt   = '0;
          end
        end
      end
      S_KICK: begin
        if (w_target == '0) begin
          w_state_nxt = S_OFF;
          w_count_nxt = '0;
        end else if (r_kick == '0) begin
          w_state_nxt = S_RAMP;
          w_pre_nxt   = '0;
        end else begin
          w_kick_nxt = r_kick - 1'b1;
        end
      end
      S_RAMP: begin
        if (r_count == w_target) begin
          w_state_nxt = (w_target != '0) ? S_HOLD : S_OFF;
        end else if (r_pre == PRE_LAST) begin
          w_pre_nxt   = '0;
          w_count_nxt = w_stepped;
          if (w_stepped == w_target) begin
            w_state_nxt = (w_target != '0) ? S_HOLD : S_OFF;
          end
        end else begin
          w_pre_nxt = r_pre + 1'b1;
        end
      end
      S_HOLD: begin
        if (w_target != r_count) begin
          w_state_nxt = S_RAMP;
          w_pre_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_OFF;
        w_count_nxt = '0;
      end
    endcase
  end

  // State and datapath registers. They advance only on enabled edges.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_OFF;
      r_count  <= '0;
      r_pre    <= '0;
      r_kick   <= '0;
      r_fan_on <= 1'b0;
    end else if (bus.clk_en_i) begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_pre    <= w_pre_nxt;
      r_kick   <= w_kick_nxt;
      r_fan_on <= (w_state_nxt != S_OFF);
    end
  end

  assign bus.counterValue_o = r_count;
  assign bus.fanOn_o        = r_fan_on;
  assign bus.state_o        = r_state;
endmodule

// File: tb/tb_fan_duty_ramp.sv
// Directed bench for fan_duty_ramp at default parameters.
module tb_fan_duty_ramp;
  logic clk_i;
  logic rst_i;
  int   checks;
  int   failures;

  fan_duty_ramp_if #(.COUNTER_BITWIDTH(8), .LEVEL_BITWIDTH(4)) bus ();

  fan_duty_ramp #(
    .COUNTER_BITWIDTH(8),
    .LEVEL_BITWIDTH(4),
    .STEP_PRESCALE(16),
    .KICK_TICKS(64)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus(bus.slave)
  );

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int cnt, input int st, input int on);
    check({tag, ".count"}, 32'(bus.counterValue_o), 32'(cnt));
    check({tag, ".state"}, 32'(bus.state_o), 32'(st));
    check({tag, ".fan_on"}, 32'(bus.fanOn_o), 32'(on));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_i           = 1'b1;
    bus.clk_en_i    = 1'b1;
    bus.level_i     = 4'd0;
    bus.step_i      = 8'd16;
    bus.kickValue_i = 8'd200;

    // Reset state, then idle with level 0
    tick(2);
    check_out("reset", 0, 0, 0);
    rst_i = 1'b0;
    tick(3);
    check_out("idle_off", 0, 0, 0);

    // Spin-up: level 8 -> target 136, kick 200, step 16
    bus.level_i = 4'd8;
    tick(1);
    check_out("kick_entry", 200, 1, 1);
    tick(63);
    check_out("kick_last", 200, 1, 1);
    tick(1);
    check_out("ramp_entry", 200, 2, 1);
    tick(15);
    check_out("ramp_pre15", 200, 2, 1);
    tick(1);
    check_out("down_step1", 184, 2, 1);
    tick(16);
    check_out("down_step2", 168, 2, 1);
    tick(16);
    check_out("down_step3", 152, 2, 1);
    tick(16);
    check_out("down_hold", 136, 3, 1);
    tick(5);
    check_out("hold_stable", 136, 3, 1);

    // Saturating up-ramp: level 15 -> 255, step 50
    bus.level_i = 4'd15;
    bus.step_i  = 8'd50;
    tick(1);
    check_out("up_ramp_entry", 136, 2, 1);
    tick(15);
    check_out("up_pre15", 136, 2, 1);
    tick(1);
    check_out("up_step1", 186, 2, 1);
    tick(16);
    check_out("up_step2", 236, 2, 1);
    tick(16);
    check_out("up_clamp", 255, 3, 1);

    // Ramp down to off with step 0 (promoted to 1)
    bus.level_i = 4'd0;
    bus.step_i  = 8'd0;
    tick(1);
    check_out("dn_entry", 255, 2, 1);
    tick(15);
    check_out("dn_pre15", 255, 2, 1);
    tick(1);
    check_out("dn_first", 254, 2, 1);
    for (int v = 253; v >= 0; v--) begin
      tick(16);
      check("dn_count", 32'(bus.counterValue_o), 32'(v));
      if (v > 0) begin
        check("dn_state", 32'(bus.state_o), 32'd2);
        check("dn_fan_on", 32'(bus.fanOn_o), 32'd1);
      end else begin
        check("dn_off_state", 32'(bus.state_o), 32'd0);
        check("dn_off_fan", 32'(bus.fanOn_o), 32'd0);
      end
    end

    // Abort kick on the 10th KICK edge
    bus.level_i     = 4'd8;
    bus.step_i      = 8'd16;
    bus.kickValue_i = 8'd200;
    tick(1);
    check_out("abort_entry", 200, 1, 1);
    tick(9);
    check_out("abort_10th", 200, 1, 1);
    bus.level_i = 4'd0;
    tick(1);
    check_out("abort_off", 0, 0, 0);

    // Enable gating mid-RAMP; kick below target, ramp goes up
    bus.level_i     = 4'd8;
    bus.kickValue_i = 8'd100;
    tick(1);
    check_out("gate_kick", 100, 1, 1);
    tick(64);
    check_out("gate_ramp", 100, 2, 1);
    tick(16);
    check_out("gate_step1", 116, 2, 1);
    tick(5);
    bus.clk_en_i = 1'b0;
    bus.level_i  = 4'd15;
    tick(100);
    check_out("gate_frozen", 116, 2, 1);
    bus.clk_en_i = 1'b1;
    bus.level_i  = 4'd8;
    tick(10);
    check_out("gate_pre15", 116, 2, 1);
    tick(1);
    check_out("gate_step2", 132, 2, 1);
    tick(16);
    check_out("gate_clamp", 136, 3, 1);

    // Asynchronous reset mid-cycle while the fan is running
    #2;
    rst_i = 1'b1;
    #1;
    check_out("async_rst", 0, 0, 0);
    bus.level_i = 4'd0;
    tick(1);
    rst_i = 1'b0;
    tick(2);
    check_out("post_rst", 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
